sdram_mp_arbiter: RTL and testbench
===================================

// Module: sdram_mp_arbiter
// PURPOSE
//  Parametrised N-master Avalon-MM arbiter for the shared SDRAM controller of the multi-core image system.
//  Scales the 2-processor layout to N_MASTERS cores that share one SDRAM slave port.
//  Supports round-robin or fixed priority arbitration.
//  Tracks outstanding reads in an ID FIFO, so each pipelined read response returns to the master that issued it.
//  Sits between the NIOS data masters and the SDRAM controller, in the clk_clk domain.
// PARAMETERS
//  N_MASTERS   2   number of requesting masters (2..8)
//  ADDR_W      24  SDRAM word address width
//  DATA_W      16  data width; DATA_W/8 byteenable bits
//  MAX_PEND    4   max outstanding reads (power of 2, 2..16)
//  RR_MODE     1   1 = round-robin, 0 = fixed priority (lowest index wins)
// PORTS
//  clk_clk          in   1              system clock; all logic rising-edge
//  reset_reset_n    in   1              synchronous active-low reset
//  m_address        in   N*ADDR_W       master i address at [i*ADDR_W +: ADDR_W]
//  m_read           in   N              read request per master
//  m_write          in   N              write request per master
//  m_writedata      in   N*DATA_W       write data per master
//  m_byteenable     in   N*DATA_W/8     byte enables per master
//  m_waitrequest    out  N              1 = command not accepted this cycle
//  m_readdata       out  DATA_W         shared read data (qualified per master)
//  m_readdatavalid  out  N              one-hot read response strobe
//  s_address        out  ADDR_W         to SDRAM controller
//  s_read           out  1              to SDRAM controller
//  s_write          out  1              to SDRAM controller
//  s_writedata      out  DATA_W         to SDRAM controller
//  s_byteenable     out  DATA_W/8       to SDRAM controller
//  s_waitrequest    in   1              from SDRAM controller
//  s_readdata       in   DATA_W         from SDRAM controller
//  s_readdatavalid  in   1              from SDRAM controller
//  pend_count       out  log2(MAX_PEND)+1  outstanding reads
//  err_orphan       out  1              sticky: readdatavalid while ID FIFO empty
// BEHAVIOUR
//  Reset (reset_reset_n=0 at a clock edge):
//   - state=IDLE; grant=0; last=N-1 (master 0 wins first); FIFO empty; pend_count=0; err_orphan=0.
//   - All s_read/s_write=0. m_waitrequest=all 1. m_readdatavalid=0.
//   - Reset mid-transaction drops all pending reads; late responses then set err_orphan after reset.
//  FSM:
//   - IDLE: req[i] = m_read[i] | m_write[i].
//     - A read-only request is ineligible while pend_count==MAX_PEND.
//     - If any request is eligible: register grant = winner, go to BUSY.
//     - RR_MODE=1: winner is the first eligible index after last, wrapping at N-1 -> 0.
//     - RR_MODE=0: winner is the lowest eligible index.
//   - BUSY: s_* mirror granted master's inputs combinationally; s_read/s_write gated by grant.
//     - m_waitrequest[grant] = s_waitrequest. All other masters see 1.
//     - Accept = !s_waitrequest. On accept: last=grant, go to IDLE.
//     - Otherwise hold grant; the master must keep its command stable (Avalon rule).
//     - If the granted master drops its request before accept, return to IDLE with no push.
//  Throughput: max 1 command per 2 cycles (one IDLE arbitration cycle per command).
//  Read latency: s_readdatavalid to m_readdatavalid is 0 cycles (combinational).
//   - m_readdata = s_readdata unconditionally.
//  ID FIFO (depth MAX_PEND, holds grant index):
//   - Push on accept of a read; pop on s_readdatavalid.
//   - m_readdatavalid[head]=1 on pop.
//   - Push and pop in the same cycle leave the count unchanged; ordering is preserved.
//   - Pointers wrap modulo MAX_PEND. Full cannot overflow, because reads are not granted at full.
//   - s_readdatavalid with FIFO empty: no strobe, err_orphan=1 (sticky until reset).
//  Writes: no response; never wait on the FIFO.
//  s_read and s_write both 1 if the master asserts both (master error; passed through).
// TESTING
//  1. Reset, then m0 write 0x000010/0xBEEF with s_waitrequest=0 -> m0 sees accept 2nd cycle; s_* match; pend_count=0.
//  2. N=2, RR: m0 and m1 issue continuous reads -> grants alternate 0,1,0,1; readdatavalid routed in issue order.
//  3. RR_MODE=0: m0 and m1 hold requests -> m0 always wins; m1 starves until m0 idles.
//  4. Issue 4 reads with no response, then m1 read -> m1 waits (pend=4); one readdatavalid -> m1 granted next IDLE.
//  5. s_waitrequest=1 for 5 cycles during m1 grant -> grant held, m0 wait=1 throughout, accept on cycle 6.
//  6. s_readdatavalid with FIFO empty -> no m_readdatavalid, err_orphan=1; reset mid-burst clears pend_count to 0.

Source files
------------

// File: rtl/sdram_mp_arbiter.sv
// N-master Avalon-MM arbiter for one shared SDRAM slave port: one IDLE arbitration cycle per command,
// command path and read-response routing are combinational; s_waitrequest stalls only the granted master.
module sdram_mp_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int MAX_PEND  = 4,
  parameter int RR_MODE   = 1
) (
  input  logic                              clk_clk,
  input  logic                              reset_reset_n,
  input  logic [N_MASTERS*ADDR_W-1:0]       m_address,
  input  logic [N_MASTERS-1:0]              m_read,
  input  logic [N_MASTERS-1:0]              m_write,
  input  logic [N_MASTERS*DATA_W-1:0]       m_writedata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0]   m_byteenable,
  output logic [N_MASTERS-1:0]              m_waitrequest,
  output logic [DATA_W-1:0]                 m_readdata,
  output logic [N_MASTERS-1:0]              m_readdatavalid,
  output logic [ADDR_W-1:0]                 s_address,
  output logic                              s_read,
  output logic                              s_write,
  output logic [DATA_W-1:0]                 s_writedata,
  output logic [DATA_W/8-1:0]               s_byteenable,
  input  logic                              s_waitrequest,
  input  logic [DATA_W-1:0]                 s_readdata,
  input  logic                              s_readdatavalid,
  output logic [$clog2(MAX_PEND):0]         pend_count,
  output logic                              err_orphan
);
  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int PW = $clog2(MAX_PEND);
  localparam int BW = DATA_W / 8;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_q, last_d;
  logic [GW-1:0]        fifo_q [MAX_PEND];
  logic [GW-1:0]        fifo_d [MAX_PEND];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW:0]          cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [N_MASTERS-1:0] elig;
  logic                 full;
  logic                 found;
  logic [GW-1:0]        win;
  logic [GW-1:0]        cand;
  logic                 busy, g_req, accept, push, pop;

  // Read-only requests are held off at full so the ID FIFO can never overflow.
  always_comb begin
    elig = '0;
    full = (cnt_q == (PW+1)'(MAX_PEND));
    for (int i = 0; i < N_MASTERS; i++) begin
      elig[i] = (m_read[i] | m_write[i]) & ~(m_read[i] & ~m_write[i] & full);
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      if (RR_MODE != 0) begin
        cand = GW'((int'(last_q) + k) % N_MASTERS);
      end else begin
        cand = GW'(k - 1);
      end
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    busy         = (state_q == BUSY);
    g_req        = m_read[grant_q] | m_write[grant_q];
    s_address    = m_address[grant_q*ADDR_W +: ADDR_W];
    s_writedata  = m_writedata[grant_q*DATA_W +: DATA_W];
    s_byteenable = m_byteenable[grant_q*BW +: BW];
    s_read       = busy & m_read[grant_q];
    s_write      = busy & m_write[grant_q];
    accept       = busy & g_req & ~s_waitrequest;
    push         = accept & m_read[grant_q];
    pop          = s_readdatavalid & (cnt_q != '0);

    m_waitrequest = '1;
    if (busy) begin
      m_waitrequest[grant_q] = s_waitrequest;
    end
    m_readdatavalid = '0;
    if (pop) begin
      m_readdatavalid[fifo_q[rd_ptr_q]] = 1'b1;
    end
    m_readdata = s_readdata;
    pend_count = cnt_q;
    err_orphan = err_q;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = win;
        end
      end
      default: begin
        // A master withdrawing its command before accept releases the bus without a push.
        if (!g_req) begin
          state_d = IDLE;
        end else if (accept) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
    endcase
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = grant_q;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (s_readdatavalid & (cnt_q == '0));
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= GW'(N_MASTERS - 1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_PEND; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fifo_q   <= fifo_d;
    end
  end

endmodule

// File: tb/tb_sdram_mp_arbiter.sv
// Directed bench for sdram_mp_arbiter: a round-robin instance plus a fixed-priority instance on shared stimulus.
module tb_sdram_mp_arbiter;
  logic        clk_clk;
  logic        reset_reset_n;
  logic [47:0] m_address;
  logic [1:0]  m_read;
  logic [1:0]  m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        s_waitrequest;
  logic [15:0] s_readdata;
  logic        s_readdatavalid;

  logic [1:0]  m_waitrequest, m_readdatavalid;
  logic [15:0] m_readdata, s_writedata;
  logic [23:0] s_address;
  logic        s_read, s_write, err_orphan;
  logic [1:0]  s_byteenable;
  logic [2:0]  pend_count;

  logic [1:0]  fp_waitrequest, fp_readdatavalid;
  logic [15:0] fp_readdata, fp_writedata;
  logic [23:0] fp_address;
  logic        fp_read, fp_write, fp_err;
  logic [1:0]  fp_byteenable;
  logic [2:0]  fp_pend;

  int          checks;
  int          failures;
  logic [1:0]  exp_wait;
  logic [1:0]  exp_rdv;
  logic [1:0]  drain_order [4];

  sdram_mp_arbiter #(.N_MASTERS(2), .ADDR_W(24), .DATA_W(16), .MAX_PEND(4), .RR_MODE(1)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .pend_count(pend_count), .err_orphan(err_orphan)
  );

  sdram_mp_arbiter #(.N_MASTERS(2), .ADDR_W(24), .DATA_W(16), .MAX_PEND(4), .RR_MODE(0)) dut_fp (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(fp_waitrequest), .m_readdata(fp_readdata), .m_readdatavalid(fp_readdatavalid),
    .s_address(fp_address), .s_read(fp_read), .s_write(fp_write),
    .s_writedata(fp_writedata), .s_byteenable(fp_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .pend_count(fp_pend), .err_orphan(fp_err)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected TB_RESULT before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset_reset_n   = 1'b0;
    m_read          = 2'b00;
    m_write         = 2'b00;
    s_waitrequest   = 1'b0;
    s_readdatavalid = 1'b0;
    tick();
    tick();
    reset_reset_n = 1'b1;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    m_address       = {24'h000020, 24'h000010};
    m_writedata     = {16'h1234, 16'hBEEF};
    m_byteenable    = 4'b0111;
    s_readdata      = 16'h0000;
    drain_order     = '{2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    settle();
    check("rst_pend", pend_count, 0);
    check("rst_err", err_orphan, 0);
    check("rst_wait", m_waitrequest, 2'b11);
    check("rst_rdv", m_readdatavalid, 2'b00);
    check("rst_s_rd_wr", {s_read, s_write}, 2'b00);

    // 1: single write from m0, accepted in its second cycle
    m_write = 2'b01;
    settle();
    check("t1_wait_c1", m_waitrequest, 2'b11);
    tick();
    settle();
    check("t1_wait_c2", m_waitrequest, 2'b10);
    check("t1_s_write", {s_read, s_write}, 2'b01);
    check("t1_s_addr", s_address, 24'h000010);
    check("t1_s_wdata", s_writedata, 16'hBEEF);
    check("t1_s_be", s_byteenable, 2'b11);
    tick();
    m_write = 2'b00;
    settle();
    check("t1_pend", pend_count, 0);
    check("t1_idle_wait", m_waitrequest, 2'b11);

    // 2: round-robin continuous reads, responses in issue order
    do_reset();
    m_read = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      settle();
      exp_wait = (k % 2 == 0) ? 2'b10 : 2'b01;
      check("t2_grant_wait", m_waitrequest, exp_wait);
      check("t2_s_addr", s_address, (k % 2 == 0) ? 24'h000010 : 24'h000020);
      tick();
      settle();
      check("t2_pend", pend_count, k + 1);
    end
    m_read = 2'b00;
    for (int j = 0; j < 4; j++) begin
      s_readdatavalid = 1'b1;
      s_readdata      = 16'hA000 + 16'(j);
      settle();
      exp_rdv = (j % 2 == 0) ? 2'b01 : 2'b10;
      check("t2_rdv", m_readdatavalid, exp_rdv);
      check("t2_rdata", m_readdata, 16'hA000 + 16'(j));
      tick();
    end
    s_readdatavalid = 1'b0;
    settle();
    check("t2_pend_drained", pend_count, 0);

    // 4: FIFO full blocks m1's read until one response pops
    m_read = 2'b01;
    repeat (8) tick();
    settle();
    check("t4_pend_full", pend_count, 4);
    m_read = 2'b10;
    for (int c = 0; c < 3; c++) begin
      tick();
      settle();
      check("t4_blocked_wait", m_waitrequest, 2'b11);
    end
    s_readdatavalid = 1'b1;
    s_readdata      = 16'h4444;
    settle();
    check("t4_pop_rdv", m_readdatavalid, 2'b01);
    tick();
    s_readdatavalid = 1'b0;
    settle();
    check("t4_pend_3", pend_count, 3);
    check("t4_still_idle", m_waitrequest, 2'b11);
    tick();
    settle();
    check("t4_m1_grant", m_waitrequest, 2'b01);
    tick();
    m_read = 2'b00;
    settle();
    check("t4_pend_refull", pend_count, 4);
    for (int j = 0; j < 4; j++) begin
      s_readdatavalid = 1'b1;
      settle();
      check("t4_drain_rdv", m_readdatavalid, drain_order[j]);
      tick();
    end
    s_readdatavalid = 1'b0;
    settle();
    check("t4_pend_empty", pend_count, 0);

    // 5: slave stalls m1's write for five cycles, m0 kept waiting
    m_write       = 2'b10;
    s_waitrequest = 1'b1;
    tick();
    m_write = 2'b11;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("t5_hold_wait", m_waitrequest, 2'b11);
      check("t5_hold_addr", s_address, 24'h000020);
      tick();
    end
    s_waitrequest = 1'b0;
    settle();
    check("t5_accept_c6", m_waitrequest, 2'b01);
    tick();
    m_write = 2'b01;
    tick();
    settle();
    check("t5_m0_next", m_waitrequest, 2'b10);
    tick();
    m_write = 2'b00;

    // granted master withdraws its read before accept: no push
    m_read        = 2'b01;
    s_waitrequest = 1'b1;
    tick();
    settle();
    check("drop_s_read_on", s_read, 1'b1);
    m_read = 2'b00;
    settle();
    check("drop_s_read_off", s_read, 1'b0);
    tick();
    settle();
    check("drop_pend", pend_count, 0);
    check("drop_idle_wait", m_waitrequest, 2'b11);
    s_waitrequest = 1'b0;

    // 3: fixed priority starves m1 while round-robin alternates
    do_reset();
    m_write = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      settle();
      check("t3_fp_m0_wins", fp_waitrequest, 2'b10);
      exp_wait = (k % 2 == 0) ? 2'b10 : 2'b01;
      check("t3_rr_alt", m_waitrequest, exp_wait);
      tick();
    end
    m_write = 2'b10;
    tick();
    settle();
    check("t3_fp_m1_after", fp_waitrequest, 2'b01);
    tick();
    m_write = 2'b00;

    // 6: orphan response, then reset with reads in flight
    do_reset();
    s_readdatavalid = 1'b1;
    settle();
    check("t6_orphan_rdv", m_readdatavalid, 2'b00);
    tick();
    s_readdatavalid = 1'b0;
    settle();
    check("t6_err_set", err_orphan, 1'b1);
    tick();
    settle();
    check("t6_err_sticky", err_orphan, 1'b1);
    m_read = 2'b01;
    repeat (4) tick();
    settle();
    check("t6_pend_2", pend_count, 2);
    reset_reset_n = 1'b0;
    m_read        = 2'b00;
    tick();
    settle();
    check("t6_rst_pend", pend_count, 0);
    check("t6_rst_err", err_orphan, 1'b0);
    reset_reset_n   = 1'b1;
    s_readdatavalid = 1'b1;
    settle();
    check("t6_late_rdv", m_readdatavalid, 2'b00);
    tick();
    s_readdatavalid = 1'b0;
    settle();
    check("t6_late_err", err_orphan, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
